// File: rtl/isp1761_bus_sched.sv
// ISP1761 parallel-bus cycle scheduler: arbitrates two requesters and runs one timed CS/strobe cycle per grant.
// Optional macro ISP_SCHED_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module isp1761_bus_sched #(
   parameter int T_SETUP   = 2,
   parameter int T_STROBE  = 3,
   parameter int T_HOLD    = 1,
   parameter int T_RECOVER = 2
) (
   input  logic        s_clk,
   input  logic        s_reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        wr0,
   input  logic        wr1,
   input  logic [16:0] addr0,
   input  logic [16:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata,
   output logic        CS_N,
   output logic        RD_N,
   output logic        WR_N,
   output logic [16:0] A,
   output logic [31:0] D_OUT,
   output logic        D_OE,
   input  logic [31:0] D_IN,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   if (T_SETUP < 1 || T_SETUP > 15 || T_STROBE < 1 || T_STROBE > 15 ||
       T_HOLD < 1 || T_HOLD > 15 || T_RECOVER < 1 || T_RECOVER > 15) begin : g_param_err
      $error("isp1761_bus_sched: timing parameters must lie in 1..15");
   end

   localparam logic [3:0] C_SETUP   = 4'(T_SETUP - 1);
   localparam logic [3:0] C_STROBE  = 4'(T_STROBE - 1);
   localparam logic [3:0] C_HOLD    = 4'(T_HOLD - 1);
   localparam logic [3:0] C_RECOVER = 4'(T_RECOVER - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STROBE  = 3'd2,
      S_HOLD    = 3'd3,
      S_RECOVER = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       gnt_q;
   logic       wr_q, wr_d;
   logic       grant_go, grant_port;
   logic       ack_d, cap_rd;
   logic       cs_act_d;

   assign grant_go = (state_q == S_IDLE) && (req0 || req1);

`ifdef ISP_SCHED_ROUND_ROBIN_EN
   // rr_q names the port that wins the next tie; it flips away from every granted port.
   logic rr_q;
   assign grant_port = (req0 && req1) ? rr_q : req1;

   always_ff @(posedge s_clk) begin
      if (s_reset)
         rr_q <= 1'b0;
      else if (grant_go)
         rr_q <= ~grant_port;
   end
`else
   assign grant_port = ~req0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      cap_rd  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_go) begin
               state_d = S_SETUP;
               cnt_d   = C_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = S_STROBE;
               cnt_d   = C_STROBE;
            end else
               cnt_d = cnt_q - 4'd1;
         end
         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_HOLD;
               cnt_d   = C_HOLD;
               cap_rd  = ~wr_q;
            end else
               cnt_d = cnt_q - 4'd1;
         end
         S_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RECOVER;
               cnt_d   = C_RECOVER;
               ack_d   = 1'b1;
            end else
               cnt_d = cnt_q - 4'd1;
         end
         S_RECOVER: begin
            if (cnt_q == 4'd0)
               state_d = S_IDLE;
            else
               cnt_d = cnt_q - 4'd1;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Pad outputs are registered from the next state so they line up with the state they describe.
   assign wr_d     = grant_go ? (grant_port ? wr1 : wr0) : wr_q;
   assign cs_act_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);

   always_ff @(posedge s_clk) begin
      if (s_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         gnt_q   <= 1'b0;
         wr_q    <= 1'b0;
         CS_N    <= 1'b1;
         RD_N    <= 1'b1;
         WR_N    <= 1'b1;
         D_OE    <= 1'b0;
         A       <= '0;
         D_OUT   <= '0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         rdata   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         CS_N    <= ~cs_act_d;
         RD_N    <= ~((state_d == S_STROBE) && !wr_d);
         WR_N    <= ~((state_d == S_STROBE) && wr_d);
         D_OE    <= cs_act_d && wr_d;
         ack0    <= ack_d && !gnt_q;
         ack1    <= ack_d && gnt_q;
         if (grant_go) begin
            gnt_q <= grant_port;
            A     <= grant_port ? addr1 : addr0;
            D_OUT <= grant_port ? wdata1 : wdata0;
         end
         if (cap_rd)
            rdata <= D_IN;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule
